// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded instruction fields and branch resolution in,
// pipeline control out.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_AW   = 3
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_load;
  logic              id_is_mul;
  logic              ex_branch_taken;
  logic              stall;
  logic              bubble;
  logic              flush_if_id;
  logic              mul_busy;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_is_load, id_is_mul, ex_branch_taken,
    input  stall, bubble, flush_if_id, mul_busy, pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_regwrite,
           id_is_load, id_is_mul, ex_branch_taken,
    output stall, bubble, flush_if_id, mul_busy, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register bypass countdown, multiplier occupancy,
// stall/bubble/flush generation. Optional HAZARD_STATS_EN adds stall/flush counters.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk,
  input  logic rst,
  hazard_scoreboard_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [CNT_W-1:0] MulInit  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] LoadInit = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] mul_cnt_q;
  logic [CNT_W-1:0] new_lat;
  logic raw1, raw2, waw, structural, hazard, issue, wr_en;

  always_comb begin
    new_lat = '0;
    if (hz.id_is_mul) begin
      new_lat = MulInit;
    end else if (hz.id_is_load) begin
      new_lat = LoadInit;
    end
    raw1       = hz.id_use_rs1 && (hz.id_rs1 != '0) && (cnt_q[hz.id_rs1] != '0);
    raw2       = hz.id_use_rs2 && (hz.id_rs2 != '0) && (cnt_q[hz.id_rs2] != '0);
    waw        = hz.id_regwrite && (hz.id_rd != '0) && (cnt_q[hz.id_rd] > new_lat);
    structural = hz.id_is_mul && (mul_cnt_q != '0);
    hazard     = hz.id_valid && (raw1 || raw2 || waw || structural);
    issue      = hz.id_valid && !hazard && !hz.ex_branch_taken;
    wr_en      = issue && hz.id_regwrite && (hz.id_rd != '0);

    // Outputs are gated by rst so they read 0 for the whole reset window.
    hz.stall       = !rst && hazard && !hz.ex_branch_taken;
    hz.bubble      = !rst && (hazard || hz.ex_branch_taken);
    hz.flush_if_id = !rst && hz.ex_branch_taken;
    hz.mul_busy    = !rst && (mul_cnt_q != '0);
    hz.pending     = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      hz.pending[i] = !rst && (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      mul_cnt_q <= '0;
    end else begin
      // A fresh issue to a register overrides that register's decrement.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (hz.id_rd == REG_AW'(i))) begin
          cnt_q[i] <= new_lat;
        end else if (cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - CNT_W'(1);
        end
      end
      if (issue && hz.id_is_mul) begin
        mul_cnt_q <= MulInit;
      end else if (mul_cnt_q != '0) begin
        mul_cnt_q <= mul_cnt_q - CNT_W'(1);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (hz.stall && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (hz.ex_branch_taken && (flush_count != 16'hFFFF)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic
// checked against a ready-time reference model.
module tb_hazard_scoreboard;
  localparam int unsigned NumRegs = 8;
  localparam int unsigned MulLat  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: absolute cycle at which each register / the multiplier is free.
  int cyc = 0;
  int ready_at [NumRegs];
  int mul_free_at = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  hazard_scoreboard_if #(.NUM_REGS(NumRegs), .REG_AW(3)) hz ();

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  hazard_scoreboard #(.NUM_REGS(NumRegs), .REG_AW(3), .MUL_LAT(MulLat), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic int rem(input int r);
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic int lat_of(input logic is_mul, input logic is_load);
    if (is_mul) return MulLat - 1;
    if (is_load) return 1;
    return 0;
  endfunction

  // {stall, bubble, flush_if_id, mul_busy, pending[7:0]}
  function automatic logic [11:0] exp_vec();
    logic haz, s;
    logic [7:0] p;
    int lat;
    if (rst) return '0;
    lat = lat_of(hz.id_is_mul, hz.id_is_load);
    haz = hz.id_valid && (
          (hz.id_use_rs1 && hz.id_rs1 != 0 && rem(int'(hz.id_rs1)) > 0) ||
          (hz.id_use_rs2 && hz.id_rs2 != 0 && rem(int'(hz.id_rs2)) > 0) ||
          (hz.id_regwrite && hz.id_rd != 0 && rem(int'(hz.id_rd)) > lat) ||
          (hz.id_is_mul && mul_free_at > cyc));
    s = haz && !hz.ex_branch_taken;
    p = '0;
    for (int i = 1; i < NumRegs; i++) p[i] = rem(i) > 0;
    return {s, s || hz.ex_branch_taken, hz.ex_branch_taken, mul_free_at > cyc, p};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {hz.stall, hz.bubble, hz.flush_if_id, hz.mul_busy, hz.pending};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NumRegs; i++) ready_at[i] = 0;
    mul_free_at = 0;
    exp_sc = 0;
    exp_fc = 0;
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic u1,
                       input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                       input logic rw, input logic ld, input logic mul, input logic br);
    hz.id_valid = v;  hz.id_rs1 = rs1; hz.id_use_rs1 = u1; hz.id_rs2 = rs2;
    hz.id_use_rs2 = u2; hz.id_rd = rd; hz.id_regwrite = rw; hz.id_is_load = ld;
    hz.id_is_mul = mul; hz.ex_branch_taken = br;
  endtask

  // Advance one clock, updating the model with whatever the current ID inputs issue.
  task automatic tick();
    logic [11:0] e;
    logic iss;
    int lat;
    e   = exp_vec();
    lat = lat_of(hz.id_is_mul, hz.id_is_load);
    iss = hz.id_valid && !e[11] && !hz.ex_branch_taken && !rst;
    if (e[11]) exp_sc++;
    if (hz.ex_branch_taken && !rst) exp_fc++;
    @(posedge clk);
    if (iss) begin
      if (hz.id_regwrite && hz.id_rd != 0) ready_at[hz.id_rd] = cyc + 1 + lat;
      if (hz.id_is_mul) mul_free_at = cyc + MulLat;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(1, 3'd2, 1, 3'd3, 1, 3'd4, 1, 1, 0, 1);
    #1;
    n_checks++;
    if (obs_vec() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs_vec(), 12'h000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(1, 3'd2, 1, 3'd3, 1, 3'd4, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_empty: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_load_use();
    int n = 0;
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 3'd2, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL load_use_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (hz.stall) begin n++; tick(); end
      else begin tick(); break; end
    end
    n_checks++;
    if (n != 1) begin
      n_fail++;
      $display("FAIL load_use_stalls: got %0d want 1", n);
    end
  endtask

  task automatic test_mul_use();
    int n = 0, mb = 0;
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd4, 1, 0, 1, 0);
    tick();
    drive(1, 3'd4, 1, 3'd1, 1, 3'd5, 1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mul_use_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (hz.mul_busy) mb++;
      if (hz.stall) begin n++; tick(); end
      else begin tick(); break; end
    end
    n_checks++;
    if (n != MulLat - 1 || mb != MulLat - 1) begin
      n_fail++;
      $display("FAIL mul_use_stalls: got %0d/%0d want %0d", n, mb, MulLat - 1);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd4, 1, 0, 1, 0);
    tick();
    drive(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b_mul_vec: got %h want %h", obs_vec(), exp_vec());
      end
      if (hz.stall) begin n++; tick(); end
      else begin tick(); break; end
    end
    n_checks++;
    if (n != MulLat - 1) begin
      n_fail++;
      $display("FAIL b2b_mul_stalls: got %0d want %0d", n, MulLat - 1);
    end
  endtask

  task automatic test_branch_squash();
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd2, 1, 1, 0, 0);
    tick();
    drive(1, 3'd2, 1, 0, 0, 3'd3, 1, 0, 0, 1);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.stall !== 1'b0 || hz.flush_if_id !== 1'b1 ||
        hz.bubble !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_override: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.pending[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_squash_pending: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_r0();
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0);
    tick();
    drive(1, 3'd0, 1, 3'd0, 1, 3'd5, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.stall !== 1'b0 || hz.pending !== 8'h00) begin
      n_fail++;
      $display("FAIL r0_untracked: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_reset_midstall();
    idle(4);
    drive(1, 0, 0, 0, 0, 3'd4, 1, 0, 1, 0);
    tick();
    drive(1, 3'd4, 1, 0, 0, 3'd6, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_stall: got %h want %h", obs_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if (obs_vec() !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), 12'h000);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    hz.ex_branch_taken = 1'b0;
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== exp_vec() || hz.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_r4: got %h want %h", obs_vec(), exp_vec());
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0] kind;
    for (int k = 0; k < 400; k++) begin
      kind = 2'($urandom_range(0, 2));
      drive(logic'($urandom_range(0, 9) < 8), 3'($urandom), logic'($urandom),
            3'($urandom), logic'($urandom), 3'($urandom), logic'($urandom_range(0, 3) != 0),
            kind == 2'd1, kind == 2'd2, logic'($urandom_range(0, 9) == 0));
      @(negedge clk);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_vec@%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      tick();
    end
`ifdef HAZARD_STATS_EN
    n_checks++;
    if (stall_cycles !== 16'(exp_sc) || flush_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d want %0d/%0d", stall_cycles, flush_count,
               exp_sc, exp_fc);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_mul_use();
    test_back_to_back();
    test_branch_squash();
    test_r0();
    test_reset_midstall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
